// File: rtl/edge_waveform_generator.sv
// edge_waveform_generator: programmable square-wave source with cycle-aligned
// rising/falling edge strobes and a done strobe on completion.
// Optional feature macro: WAVEGEN_ABORT_EN adds an 'abort' input that ends an
// active wave on the next cycle.
module edge_waveform_generator #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] low_cnt,
  input  logic [CNT_W-1:0] num_cycles,
`ifdef WAVEGEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             clock_signal,
  output logic             pose_edge,
  output logic             neg_edge,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] h_len, h_len_next;
  logic [CNT_W-1:0] l_len, l_len_next;
  logic [CNT_W-1:0] n_len, n_len_next;
  logic [CNT_W-1:0] phase_cnt, phase_next;
  logic [CNT_W-1:0] period_cnt, period_next;
  logic [CNT_W-1:0] period_inc;
  logic [CNT_W-1:0] h_start, l_start;
  logic             stop_pending, stop_pending_next;
  logic             clock_next, pose_next, neg_next, done_next;
  logic             phase_zero, last_period, abort_req;

  // Zero phase lengths are promoted to one cycle
  assign h_start    = (high_cnt == '0) ? CNT_W'(1) : high_cnt;
  assign l_start    = (low_cnt  == '0) ? CNT_W'(1) : low_cnt;
  assign phase_zero = (phase_cnt == '0);
  assign period_inc = period_cnt + CNT_W'(1);
  // A stop seen in the final LOW cycle still ends the wave there
  assign last_period = ((n_len != '0) && (period_inc == n_len)) || stop_pending || stop;

`ifdef WAVEGEN_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign busy = (state != IDLE);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      h_len        <= '0;
      l_len        <= '0;
      n_len        <= '0;
      phase_cnt    <= '0;
      period_cnt   <= '0;
      stop_pending <= 1'b0;
      clock_signal <= 1'b0;
      pose_edge    <= 1'b0;
      neg_edge     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      h_len        <= h_len_next;
      l_len        <= l_len_next;
      n_len        <= n_len_next;
      phase_cnt    <= phase_next;
      period_cnt   <= period_next;
      stop_pending <= stop_pending_next;
      clock_signal <= clock_next;
      pose_edge    <= pose_next;
      neg_edge     <= neg_next;
      done         <= done_next;
    end
  end

  // Next-state decode; abort overrides phase expiry and stop
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = HIGH;
      HIGH:    if (phase_zero) state_next = LOW;
      LOW:     if (phase_zero) state_next = last_period ? IDLE : HIGH;
      default: state_next = IDLE;
    endcase
    if (abort_req) state_next = IDLE;
  end

  // Next values for the registered outputs, counters and latched settings
  always_comb begin
    h_len_next        = h_len;
    l_len_next        = l_len;
    n_len_next        = n_len;
    phase_next        = phase_cnt;
    period_next       = period_cnt;
    stop_pending_next = stop_pending | ((state != IDLE) & stop);
    clock_next        = clock_signal;
    pose_next         = 1'b0;
    neg_next          = 1'b0;
    done_next         = 1'b0;
    case (state)
      IDLE: begin
        stop_pending_next = 1'b0;
        clock_next        = 1'b0;
        if (start) begin
          h_len_next  = h_start;
          l_len_next  = l_start;
          n_len_next  = num_cycles;
          phase_next  = h_start - CNT_W'(1);
          period_next = '0;
          clock_next  = 1'b1;
          pose_next   = 1'b1;
        end
      end
      HIGH: begin
        if (phase_zero) begin
          clock_next = 1'b0;
          neg_next   = 1'b1;
          phase_next = l_len - CNT_W'(1);
        end else begin
          phase_next = phase_cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (phase_zero) begin
          period_next = period_inc;
          if (last_period) begin
            done_next         = 1'b1;
            stop_pending_next = 1'b0;
          end else begin
            clock_next = 1'b1;
            pose_next  = 1'b1;
            phase_next = h_len - CNT_W'(1);
          end
        end else begin
          phase_next = phase_cnt - CNT_W'(1);
        end
      end
      default: begin
        clock_next = 1'b0;
      end
    endcase
    if (abort_req) begin
      clock_next        = 1'b0;
      pose_next         = 1'b0;
      neg_next          = clock_signal;
      done_next         = 1'b1;
      stop_pending_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_edge_waveform_generator.sv
// Scoreboard bench for edge_waveform_generator: a time-since-start reference
// model pushes expected outputs per cycle, a monitor pops and compares.
module tb_edge_waveform_generator;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] high_cnt = '0;
  logic [CNT_W-1:0] low_cnt = '0;
  logic [CNT_W-1:0] num_cycles = '0;
  logic             clock_signal, pose_edge, neg_edge, busy, done;

  typedef struct packed {
    logic cs;
    logic pe;
    logic ne;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  edge_waveform_generator #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .high_cnt     (high_cnt),
    .low_cnt      (low_cnt),
    .num_cycles   (num_cycles),
`ifdef WAVEGEN_ABORT_EN
    .abort        (abort),
`endif
    .clock_signal (clock_signal),
    .pose_edge    (pose_edge),
    .neg_edge     (neg_edge),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference model: the wave is a function of the cycle index since start
  int   m_active = 0;
  int   m_t = 0;
  int   m_h = 1;
  int   m_l = 1;
  int   m_limit = 0;
  logic m_cs = 1'b0;
  logic abort_eff;

`ifdef WAVEGEN_ABORT_EN
  assign abort_eff = abort;
`else
  assign abort_eff = 1'b0;
`endif

  function automatic exp_t wave_at(int t, int h, int l);
    exp_t e;
    int   ph;
    ph     = (t - 1) % (h + l);
    e      = '0;
    e.cs   = (ph < h);
    e.pe   = (ph == 0);
    e.ne   = (ph == h);
    e.busy = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   p, per;
    e = '0;
    if (reset) begin
      m_active = 0;
    end else if (m_active == 0) begin
      if (start) begin
        m_h      = (high_cnt == 0) ? 1 : int'(high_cnt);
        m_l      = (low_cnt == 0) ? 1 : int'(low_cnt);
        m_limit  = int'(num_cycles);
        m_t      = 1;
        m_active = 1;
        e        = wave_at(m_t, m_h, m_l);
      end
    end else if (abort_eff) begin
      e.ne     = m_cs;
      e.done   = 1'b1;
      m_active = 0;
    end else begin
      p = m_h + m_l;
      if (stop) begin
        per = (m_t - 1) / p + 1;
        if (m_limit == 0 || per < m_limit) m_limit = per;
      end
      m_t = m_t + 1;
      if (m_limit != 0 && m_t > m_limit * p) begin
        e.done   = 1'b1;
        m_active = 0;
      end else begin
        e = wave_at(m_t, m_h, m_l);
      end
    end
    m_cs = e.cs;
    exp_q.push_back(e);
  end

  // Monitor: compare each registered output vector just after the edge
  always @(posedge clk) begin
    exp_t e, got;
    #1;
    got = '{cs: clock_signal, pe: pose_edge, ne: neg_edge, busy: busy, done: done};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got %b", $time, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL wave t=%0t cs/pe/ne/busy/done got %b required %b", $time, got, e);
      end
    end
    n_checks++;
    if (pose_edge && neg_edge) begin
      n_fail++;
      $display("FAIL strobe_overlap t=%0t got pe=%b ne=%b required not both", $time, pose_edge, neg_edge);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic kick(int h, int l, int n);
    high_cnt   = CNT_W'(h);
    low_cnt    = CNT_W'(l);
    num_cycles = CNT_W'(n);
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(2);
    // H=2 L=3 N=2
    kick(2, 3, 2);
    cyc(14);
    // zero lengths promoted to one
    kick(0, 0, 3);
    cyc(10);
    // graceful stop in the HIGH phase of period two, then restart
    kick(2, 3, 0);
    cyc(5);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(5);
    kick(2, 3, 1);
    cyc(8);
    // reset mid-wave
    kick(4, 4, 0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    kick(4, 4, 1);
    cyc(12);
    // start while busy with altered counts is ignored
    kick(3, 2, 1);
    high_cnt = CNT_W'(9);
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    cyc(8);
    // stop in the final LOW cycle and start+stop together in IDLE
    high_cnt = CNT_W'(1);
    low_cnt  = CNT_W'(2);
    num_cycles = '0;
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    cyc(2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(4);
`ifdef WAVEGEN_ABORT_EN
    kick(5, 5, 0);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(4);
    kick(2, 2, 0);
    cyc(3);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(3);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(7) == 0);
      stop       = ($urandom_range(29) == 0);
      reset      = ($urandom_range(199) == 0);
      abort      = ($urandom_range(59) == 0);
      high_cnt   = CNT_W'($urandom_range(4));
      low_cnt    = CNT_W'($urandom_range(4));
      num_cycles = CNT_W'($urandom_range(3));
      cyc(1);
    end
    start = 1'b0;
    stop  = 1'b1;
    abort = 1'b0;
    reset = 1'b0;
    cyc(1);
    stop = 1'b0;
    cyc(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
